// File: rtl/fold_seq_pkg.sv
// -----------------------------------------------------------------------------
// fold_seq_pkg
// Shared types and constants for the XOR-fold sequencer.
//   FOLD_IN_W    width of one operand segment consumed per cycle
//   FOLD_OUT_W   width of the fold result / signature
//   fold_state_t sequencer states
// Configuration macro used by this slice: FOLD_SEQ_OVERLAP_EN (see fold_seq_ctrl).
// -----------------------------------------------------------------------------
package fold_seq_pkg;

    localparam int FOLD_IN_W  = 16;
    localparam int FOLD_OUT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fold_state_t;

endpackage

// File: rtl/fold16_to_8.sv
// -----------------------------------------------------------------------------
// fold16_to_8
// Combinational 16->8 XOR fold: z = v[7:0] ^ v[15:8].
// Ports:
//   v  in   16  segment to fold
//   z  out  8   folded byte
// -----------------------------------------------------------------------------
module fold16_to_8
    import fold_seq_pkg::*;
(
    input  logic [FOLD_IN_W-1:0]  v,
    output logic [FOLD_OUT_W-1:0] z
);

    assign z = v[FOLD_OUT_W-1:0] ^ v[FOLD_IN_W-1:FOLD_OUT_W];

endmodule

// File: rtl/fold_seq_ctrl.sv
// -----------------------------------------------------------------------------
// fold_seq_ctrl
// Reduces two IN_W-bit operands to 8-bit XOR-fold signatures, one 16-bit
// segment per cycle through a shared fold lane per operand.
// Ports:
//   clk        in   1     clock, rising edge
//   rst_n      in   1     asynchronous active-low reset
//   in_valid   in   1     in_a/in_b valid
//   in_ready   out  1     block can accept a word
//   in_a       in   IN_W  operand a
//   in_b       in   IN_W  operand b
//   out_valid  out  1     out_aa/out_bb valid
//   out_ready  in   1     consumer accepts result
//   out_aa     out  8     fold signature of a
//   out_bb     out  8     fold signature of b
//   busy       out  1     state != IDLE
// Parameters:
//   IN_W  operand width, multiple of 16 and >= 16
// Macro:
//   FOLD_SEQ_OVERLAP_EN  accept the next word in DONE while the result retires
//
// state | meaning
// IDLE  | waiting for a word, in_ready=1
// RUN   | folding one 16-bit segment per cycle
// DONE  | result presented, held until out_ready
// -----------------------------------------------------------------------------
module fold_seq_ctrl
    import fold_seq_pkg::*;
#(
    parameter int IN_W = 64
)
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [IN_W-1:0]       in_a,
    input  logic [IN_W-1:0]       in_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [FOLD_OUT_W-1:0] out_aa,
    output logic [FOLD_OUT_W-1:0] out_bb,
    output logic                  busy
);

    localparam int NUM_SEG = IN_W / FOLD_IN_W;
    localparam int SEG_W   = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1;
    localparam logic [SEG_W-1:0] LAST_SEG = SEG_W'(NUM_SEG - 1);

    if ((IN_W < FOLD_IN_W) || ((IN_W % FOLD_IN_W) != 0)) begin : g_bad_in_w
        $error("fold_seq_ctrl: IN_W=%0d must be a multiple of 16 and >= 16", IN_W);
    end

    fold_state_t           state;
    logic [SEG_W-1:0]      seg_cnt;
    logic [IN_W-1:0]       sh_a;
    logic [IN_W-1:0]       sh_b;
    logic [FOLD_OUT_W-1:0] acc_a;
    logic [FOLD_OUT_W-1:0] acc_b;
    logic [FOLD_OUT_W-1:0] fold_a;
    logic [FOLD_OUT_W-1:0] fold_b;
    logic [FOLD_OUT_W-1:0] acc_a_nxt;
    logic [FOLD_OUT_W-1:0] acc_b_nxt;

    fold16_to_8 u_fold_a (.v(sh_a[FOLD_IN_W-1:0]), .z(fold_a));
    fold16_to_8 u_fold_b (.v(sh_b[FOLD_IN_W-1:0]), .z(fold_b));

    assign acc_a_nxt = acc_a ^ fold_a;
    assign acc_b_nxt = acc_b ^ fold_b;

`ifdef FOLD_SEQ_OVERLAP_EN
    // In DONE the slot frees exactly when the result retires.
    assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
`else
    assign in_ready = (state == IDLE);
`endif

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            seg_cnt   <= '0;
            sh_a      <= '0;
            sh_b      <= '0;
            acc_a     <= '0;
            acc_b     <= '0;
            out_valid <= 1'b0;
            out_aa    <= '0;
            out_bb    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sh_a    <= in_a;
                        sh_b    <= in_b;
                        acc_a   <= '0;
                        acc_b   <= '0;
                        seg_cnt <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    acc_a <= acc_a_nxt;
                    acc_b <= acc_b_nxt;
                    sh_a  <= sh_a >> FOLD_IN_W;
                    sh_b  <= sh_b >> FOLD_IN_W;
                    if (seg_cnt == LAST_SEG) begin
                        // Present the final accumulation directly so the result
                        // is visible on the same edge that enters DONE.
                        out_aa    <= acc_a_nxt;
                        out_bb    <= acc_b_nxt;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        seg_cnt <= seg_cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
`ifdef FOLD_SEQ_OVERLAP_EN
                        if (in_valid) begin
                            sh_a    <= in_a;
                            sh_b    <= in_b;
                            acc_a   <= '0;
                            acc_b   <= '0;
                            seg_cnt <= '0;
                            state   <= RUN;
                        end else begin
                            state <= IDLE;
                        end
`else
                        state <= IDLE;
`endif
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fold_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fold_seq_ctrl
// Directed bench for fold_seq_ctrl: a 64-bit instance driven from a vector
// table plus hand-written multi-cycle sequences, and a 16-bit instance for the
// single-segment case.
// -----------------------------------------------------------------------------
module tb_fold_seq_ctrl;

    logic        clk;
    logic        rst_n;

    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_a;
    logic [63:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_aa;
    logic [7:0]  out_bb;
    logic        busy;

    logic        s_in_valid;
    logic        s_in_ready;
    logic [15:0] s_in_a;
    logic [15:0] s_in_b;
    logic        s_out_valid;
    logic        s_out_ready;
    logic [7:0]  s_out_aa;
    logic [7:0]  s_out_bb;
    logic        s_busy;

    int n_checks;
    int n_fail;

    fold_seq_ctrl #(.IN_W(64)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_aa    (out_aa),
        .out_bb    (out_bb),
        .busy      (busy)
    );

    fold_seq_ctrl #(.IN_W(16)) dut16 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (s_in_valid),
        .in_ready  (s_in_ready),
        .in_a      (s_in_a),
        .in_b      (s_in_b),
        .out_valid (s_out_valid),
        .out_ready (s_out_ready),
        .out_aa    (s_out_aa),
        .out_bb    (s_out_bb),
        .busy      (s_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [63:0] a;
        logic [63:0] b;
        logic [7:0]  aa;
        logic [7:0]  bb;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Count edges from the accept edge until out_valid is seen, bounded.
    task automatic wait_result(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!out_valid && n < 20);
    endtask

    task automatic run_word(input vec_t v);
        int lat;
        @(negedge clk);
        check({v.name, " in_ready idle"}, 64'(in_ready), 64'd1);
        in_a     = v.a;
        in_b     = v.b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check({v.name, " busy after accept"}, 64'(busy), 64'd1);
        wait_result(lat);
        check({v.name, " latency"}, 64'(lat), 64'd4);
        check({v.name, " out_aa"}, 64'(out_aa), 64'(v.aa));
        check({v.name, " out_bb"}, 64'(out_bb), 64'(v.bb));
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({v.name, " out_valid retired"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        int t1;
        int t2;
        int cyc;
        int lat;
        logic [7:0] held_aa;
        logic [7:0] held_bb;

        n_checks = 0;
        n_fail   = 0;

        vecs[0] = '{"spec_a", 64'h0102_0408_1020_4080, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 8'h00};
        vecs[1] = '{"spec_b", 64'h0123_4567_89AB_CDEF, 64'h0000_0000_0000_00A5, 8'h00, 8'hA5};
        vecs[2] = '{"zeros",  64'h0,                   64'h0,                   8'h00, 8'h00};
        vecs[3] = '{"top_seg", 64'hAA00_0000_0000_0000, 64'h0000_0055_0000_0000, 8'hAA, 8'h55};
        vecs[4] = '{"mixed",  64'h8000_0000_0000_0001, 64'h0000_0000_0000_FF00, 8'h81, 8'hFF};

        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_a        = '0;
        in_b        = '0;
        out_ready   = 1'b0;
        s_in_valid  = 1'b0;
        s_in_a      = '0;
        s_in_b      = '0;
        s_out_ready = 1'b0;

        #12;
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset in_ready", 64'(in_ready), 64'd1);
        check("reset out_aa", 64'(out_aa), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) run_word(vecs[i]);

        // Backpressure: hold result 5 cycles with a competing word offered.
        @(negedge clk);
        in_a     = vecs[0].a;
        in_b     = vecs[0].b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_a     = vecs[1].a;
        in_b     = vecs[1].b;
        wait_result(lat);
        check("bp latency", 64'(lat), 64'd4);
        held_aa = out_aa;
        held_bb = out_bb;
        check("bp out_aa", 64'(held_aa), 64'hFF);
        check("bp out_bb", 64'(held_bb), 64'h00);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check("bp out_valid held", 64'(out_valid), 64'd1);
            check("bp out_aa stable", 64'(out_aa), 64'(held_aa));
            check("bp out_bb stable", 64'(out_bb), 64'(held_bb));
            check("bp in_ready low", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp retired out_valid", 64'(out_valid), 64'd0);
        check("bp new word not taken", 64'(busy), 64'd0);

        // Back-to-back with in_valid and out_ready held high.
        @(negedge clk);
        in_a      = vecs[3].a;
        in_b      = vecs[3].b;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        t1  = -1;
        t2  = -1;
        cyc = 0;
        while (t2 < 0 && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
            if (out_valid) begin
                if (t1 < 0) t1 = cyc;
                else        t2 = cyc;
            end
        end
        in_valid = 1'b0;
        check("b2b second aa", 64'(out_aa), 64'hAA);
`ifdef FOLD_SEQ_OVERLAP_EN
        check("b2b spacing", 64'(t2 - t1), 64'd5);
`else
        check("b2b spacing", 64'(t2 - t1), 64'd6);
`endif
        cyc = 0;
        while (busy && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        out_ready = 1'b0;
        check("b2b drained", 64'(busy), 64'd0);

        // Reset mid-RUN discards the word and clears the held result.
        @(negedge clk);
        in_a     = vecs[0].a;
        in_b     = vecs[0].b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("mid-run busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("rst busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst out_valid", 64'(out_valid), 64'd0);
        check("rst busy after release", 64'(busy), 64'd0);
        check("rst in_ready", 64'(in_ready), 64'd1);
        check("rst out_aa", 64'(out_aa), 64'd0);
        check("rst out_bb", 64'(out_bb), 64'd0);

        // Single-segment instance.
        @(negedge clk);
        s_in_a     = 16'h3C5A;
        s_in_b     = 16'h00F0;
        s_in_valid = 1'b1;
        @(posedge clk);
        #1;
        s_in_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!s_out_valid && lat < 20);
        check("w16 latency", 64'(lat), 64'd1);
        check("w16 out_aa", 64'(s_out_aa), 64'h66);
        check("w16 out_bb", 64'(s_out_bb), 64'hF0);
        @(negedge clk);
        s_out_ready = 1'b1;
        @(posedge clk);
        #1;
        s_out_ready = 1'b0;
        check("w16 retired", 64'(s_busy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
